// File: rtl/dwg_string_ctrl.sv
// rtl/dwg_string_ctrl.sv - digital-waveguide string loop controller driving a circular delay-line RAM
module dwg_string_ctrl #(
    parameter int DW = 18,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_tick,
    input  logic          pluck,
    input  logic [AW-1:0] len,
    input  logic [7:0]    damp,
    output logic          ram_wrt,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_i,
    input  logic [DW-1:0] ram_o,
    output logic [DW-1:0] out_sample,
    output logic          out_valid,
    output logic          busy
);

    // Noise generator is fixed at 18 bits; the fill word maps it onto an 18-bit sample.
    localparam logic [17:0] LFSR_SEED = 18'h2AAAA;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        FILL  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic [AW-1:0] r_len_q, w_len_q_nxt;
    logic [AW-1:0] r_k, w_k_nxt;
    logic [DW-1:0] r_prev, w_prev_nxt;
    logic [DW-1:0] r_x, w_x_nxt;
    logic [17:0]   r_lfsr, w_lfsr_nxt;
    logic          r_pluck_pend, w_pluck_pend_nxt;
    logic          r_ram_wrt, w_ram_wrt_nxt;
    logic [AW-1:0] r_ram_a, w_ram_a_nxt;
    logic [DW-1:0] r_ram_i, w_ram_i_nxt;
    logic [DW-1:0] r_out_sample, w_out_sample_nxt;
    logic          r_out_valid, w_out_valid_nxt;
    logic          r_busy, w_busy_nxt;

    // Filter datapath: two-tap average of the oldest sample and the previous one, then damping.
    logic signed [DW:0]   w_sum;
    logic signed [DW-1:0] w_avg;
    logic signed [DW+8:0] w_prod;
    logic signed [DW-1:0] w_y;
    logic [AW-1:0]        w_len_clamp;

    assign w_sum       = $signed({ram_o[DW-1], ram_o}) + $signed({r_prev[DW-1], r_prev});
    assign w_avg       = DW'(w_sum >>> 1);
    assign w_prod      = w_avg * $signed({1'b0, damp});
    assign w_y         = DW'(w_prod >>> 8);
    assign w_len_clamp = (len < AW'(2)) ? AW'(2) : len;

    assign ram_wrt    = r_ram_wrt;
    assign ram_a      = r_ram_a;
    assign ram_i      = r_ram_i;
    assign out_sample = r_out_sample;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_len_q      <= {AW{1'b1}};
            r_k          <= '0;
            r_prev       <= '0;
            r_x          <= '0;
            r_lfsr       <= LFSR_SEED;
            r_pluck_pend <= 1'b0;
            r_ram_wrt    <= 1'b0;
            r_ram_a      <= '0;
            r_ram_i      <= '0;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_len_q      <= w_len_q_nxt;
            r_k          <= w_k_nxt;
            r_prev       <= w_prev_nxt;
            r_x          <= w_x_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_pluck_pend <= w_pluck_pend_nxt;
            r_ram_wrt    <= w_ram_wrt_nxt;
            r_ram_a      <= w_ram_a_nxt;
            r_ram_i      <= w_ram_i_nxt;
            r_out_sample <= w_out_sample_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode; strobes default low, everything else holds.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_len_q_nxt      = r_len_q;
        w_k_nxt          = r_k;
        w_prev_nxt       = r_prev;
        w_x_nxt          = r_x;
        w_lfsr_nxt       = r_lfsr;
        w_pluck_pend_nxt = r_pluck_pend;
        w_ram_wrt_nxt    = 1'b0;
        w_ram_a_nxt      = r_ram_a;
        w_ram_i_nxt      = r_ram_i;
        w_out_sample_nxt = r_out_sample;
        w_out_valid_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                // A pluck (fresh or remembered) wins; a tick in the same cycle is lost.
                if (pluck || r_pluck_pend) begin
                    w_state_nxt      = FILL;
                    w_len_q_nxt      = w_len_clamp;
                    w_ptr_nxt        = '0;
                    w_prev_nxt       = '0;
                    w_k_nxt          = '0;
                    w_pluck_pend_nxt = 1'b0;
                end else if (sample_tick) begin
                    w_state_nxt = READ;
                    w_ram_a_nxt = r_ptr;
                end
            end
            READ: begin
                if (pluck) w_pluck_pend_nxt = 1'b1;
                w_state_nxt = CAPT;
            end
            CAPT: begin
                if (pluck) w_pluck_pend_nxt = 1'b1;
                w_x_nxt          = ram_o;
                w_ram_i_nxt      = w_y;
                w_ram_wrt_nxt    = 1'b1;
                w_out_sample_nxt = w_y;
                w_out_valid_nxt  = 1'b1;
                w_state_nxt      = WRITE;
            end
            WRITE: begin
                if (pluck) w_pluck_pend_nxt = 1'b1;
                w_prev_nxt  = r_x;
                w_ptr_nxt   = (r_ptr == r_len_q - AW'(1)) ? '0 : r_ptr + AW'(1);
                w_state_nxt = IDLE;
            end
            FILL: begin
                // k reaching len_q means the last noise word has just been written.
                if (r_k == r_len_q) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ram_a_nxt   = r_k;
                    w_ram_wrt_nxt = 1'b1;
                    w_ram_i_nxt   = {{2{r_lfsr[17]}}, r_lfsr[17:2]};
                    w_lfsr_nxt    = {r_lfsr[16:0], r_lfsr[17] ^ r_lfsr[10]};
                    w_k_nxt       = r_k + AW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

endmodule

// File: tb/tb_dwg_string_ctrl.sv
// tb/tb_dwg_string_ctrl.sv - directed self-checking bench for dwg_string_ctrl
module tb_dwg_string_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic        pluck;
    logic [10:0] len;
    logic [7:0]  damp;
    logic        ram_wrt;
    logic [10:0] ram_a;
    logic [17:0] ram_i;
    logic [17:0] ram_o;
    logic [17:0] out_sample;
    logic        out_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] mem [0:2047];
    logic        bd_we = 1'b0;
    logic [10:0] bd_a = '0;
    logic [17:0] bd_d = '0;

    logic [10:0] wr_a_q[$];
    logic [17:0] wr_d_q[$];
    logic [10:0] rd_a_q[$];
    int          ov_cnt = 0;

    int base_w, base_r, base_ov;

    dwg_string_ctrl #(.DW(18), .AW(11)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .pluck       (pluck),
        .len         (len),
        .damp        (damp),
        .ram_wrt     (ram_wrt),
        .ram_a       (ram_a),
        .ram_i       (ram_i),
        .ram_o       (ram_o),
        .out_sample  (out_sample),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Write-first delay-line RAM model with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) mem[bd_a] <= bd_d;
        else if (ram_wrt) mem[ram_a] <= ram_i;
        ram_o <= ram_wrt ? ram_i : mem[ram_a];
    end

    // Log writes and output strobes away from the active edge.
    always @(negedge clk) begin
        if (ram_wrt) begin
            wr_a_q.push_back(ram_a);
            wr_d_q.push_back(ram_i);
        end
        if (out_valid) begin
            ov_cnt = ov_cnt + 1;
            rd_a_q.push_back(ram_a);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input int a, input int d);
        bd_we = 1'b1;
        bd_a  = a[10:0];
        bd_d  = d[17:0];
        step();
        bd_we = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 200) begin
            step();
            i++;
        end
        check("idle_wait", int'(busy), 0);
    endtask

    task automatic do_pluck(input int l);
        len   = l[10:0];
        pluck = 1'b1;
        step();
        pluck = 1'b0;
        wait_idle();
    endtask

    task automatic tick_gap(input int n);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (n - 1) step();
    endtask

    initial begin
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        pluck       = 1'b0;
        len         = 11'd4;
        damp        = 8'd128;
        repeat (3) step();

        check("rst_ram_wrt", int'(ram_wrt), 0);
        check("rst_ram_a", int'(ram_a), 0);
        check("rst_ram_i", int'(ram_i), 0);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        step();

        // Pluck len=4: four noise writes at 0..3, no output strobe.
        base_w  = wr_a_q.size();
        base_ov = ov_cnt;
        do_pluck(4);
        check("fill_nwr", wr_a_q.size() - base_w, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fill_addr%0d", i), int'(wr_a_q[base_w + i]), i);
        check("fill_d0", int'(wr_d_q[base_w]), 32'h3AAAA);
        check("fill_d1", int'(wr_d_q[base_w + 1]), 32'h05555);
        check("fill_no_ov", ov_cnt - base_ov, 0);
        check("fill_busy", int'(busy), 0);

        // Filter: x=200,prev=0 -> 50; then x=1000,prev=200,damp=128 -> 300.
        preload(0, 200);
        preload(1, 1000);
        damp = 8'd128;
        tick_gap(3);
        check("y_first", $signed(out_sample), 50);
        repeat (2) step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("lat_busy_e0", int'(busy), 1);
        check("lat_ov_e0", int'(out_valid), 0);
        step();
        check("lat_ov_e1", int'(out_valid), 0);
        step();
        check("lat_ov_e2", int'(out_valid), 1);
        check("y_300", $signed(out_sample), 300);
        check("wr_en_e2", int'(ram_wrt), 1);
        check("wr_addr_e2", int'(ram_a), 1);
        check("wr_data_e2", int'(ram_i), 300);
        step();
        check("ov_drop_e3", int'(out_valid), 0);
        check("busy_e3", int'(busy), 0);
        check("mem1_300", int'(mem[1]), 300);
        step();

        // Sign and floor: x=-3,prev=0,damp=255 -> -2; then x=0,prev=-3 -> -2.
        do_pluck(4);
        preload(0, -3);
        preload(1, 0);
        damp = 8'd255;
        tick_gap(3);
        check("y_neg_a", $signed(out_sample), -2);
        repeat (5) step();
        tick_gap(3);
        check("y_neg_b", $signed(out_sample), -2);
        repeat (5) step();

        // Wrap: six ticks with len 4 -> addresses 0,1,2,3,0,1.
        do_pluck(4);
        base_r = rd_a_q.size();
        base_w = wr_a_q.size();
        for (int i = 0; i < 6; i++) tick_gap(8);
        check("wrap_nrd", rd_a_q.size() - base_r, 6);
        check("wrap_nwr", wr_a_q.size() - base_w, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wrap_rd%0d", i), int'(rd_a_q[base_r + i]), i % 4);
            check($sformatf("wrap_wr%0d", i), int'(wr_a_q[base_w + i]), i % 4);
        end

        // Tick while busy is dropped.
        base_ov = ov_cnt;
        base_w  = wr_a_q.size();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (8) step();
        check("drop_ov", ov_cnt - base_ov, 1);
        check("drop_wr", wr_a_q.size() - base_w, 1);

        // Pluck and tick together: fill only.
        base_ov = ov_cnt;
        base_w  = wr_a_q.size();
        pluck       = 1'b1;
        sample_tick = 1'b1;
        step();
        pluck       = 1'b0;
        sample_tick = 1'b0;
        wait_idle();
        check("pt_ov", ov_cnt - base_ov, 0);
        check("pt_wr", wr_a_q.size() - base_w, 4);

        // Pluck during CAPT, then reset in the middle of the fill.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        pluck = 1'b1;
        step();
        pluck = 1'b0;
        check("pc_wr_e2", int'(ram_wrt), 1);
        check("pc_ov_e2", int'(out_valid), 1);
        step();
        check("pc_idle_busy", int'(busy), 0);
        check("pc_idle_wr", int'(ram_wrt), 0);
        step();
        check("pc_fill_busy", int'(busy), 1);
        check("pc_fill_wr0", int'(ram_wrt), 0);
        step();
        check("pc_k0_wr", int'(ram_wrt), 1);
        check("pc_k0_a", int'(ram_a), 0);
        step();
        check("pc_k1_a", int'(ram_a), 1);
        step();
        check("pc_k2_a", int'(ram_a), 2);
        rst_n = 1'b0;
        step();
        check("mr_ram_wrt", int'(ram_wrt), 0);
        check("mr_ram_a", int'(ram_a), 0);
        check("mr_ram_i", int'(ram_i), 0);
        check("mr_out_sample", int'(out_sample), 0);
        check("mr_out_valid", int'(out_valid), 0);
        check("mr_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
